// File: rtl/stream_sort_pkg.sv
// stream_sort_pkg: shared types, sizing helpers and the unsigned <= comparator for the batch sorter
package stream_sort_pkg;
    typedef enum logic {LOAD, EMIT} state_t;
    localparam int N_DEF = 5;
    localparam int W_DEF = 4;
    function automatic int med_idx(input int n);
        return (n - 1) / 2;
    endfunction
    function automatic int cw_of(input int n);
        return $clog2(n + 1);
    endfunction
    function automatic logic le_u(input logic [15:0] a, input logic [15:0] b);
        return a <= b;
    endfunction
endpackage

// File: rtl/stream_sort_median_sort_insert_cell.sv
// sort_insert_cell: one sorted-buffer slot that keeps, loads the new sample, or takes its lower neighbour
module sort_insert_cell
    import stream_sort_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_acc,
    input  logic [W-1:0] i_din,
    input  logic         i_low_le,
    input  logic [W-1:0] i_low_data,
    input  logic         i_low_vld,
    output logic         o_le,
    output logic [W-1:0] o_data,
    output logic         o_vld
);
    logic [W-1:0] r_data;
    logic         r_vld;
    logic         w_keep;
    logic [W-1:0] w_nxt_data;
    logic         w_nxt_vld;
    // a valid slot holding a value <= the new sample sits below the insertion point
    assign o_le   = r_vld & le_u(16'(r_data), 16'(i_din));
    assign w_keep = !i_acc | o_le;
    assign o_data = r_data;
    assign o_vld  = r_vld;
    always_comb begin
        w_nxt_data = w_keep ? r_data : (i_low_le ? i_din : i_low_data);
        w_nxt_vld  = w_keep ? r_vld : (i_low_le | i_low_vld);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_data <= w_nxt_data;
            r_vld  <= !i_clr & w_nxt_vld;
        end
    end
endmodule

// File: rtl/stream_sort_median.sv
// stream_sort_median: insertion-sorts a batch of N samples, then emits its median and the ascending replay
module stream_sort_median
    import stream_sort_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic [W-1:0] median,
    output logic         median_valid
);
    localparam int MED_IDX = med_idx(N);
    localparam int CW      = cw_of(N);
    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_rd_idx;
    logic [W-1:0]  r_median;
    logic          r_med_vld;
    logic [W-1:0]  w_data [N];
    logic [N-1:0]  w_le;
    logic [N-1:0]  w_vld;
    logic          w_acc;
    logic          w_take;
    logic          w_done;
    logic          w_clr;
    logic          w_unused;
    assign in_ready     = r_state == LOAD;
    assign out_valid    = r_state == EMIT;
    assign w_acc        = in_valid & in_ready;
    assign w_take       = out_valid & out_ready;
    assign w_done       = w_acc && r_count == CW'(N - 1);
    assign out_last     = out_valid && r_rd_idx == CW'(N - 1);
    assign w_clr        = w_take & out_last;
    assign out_data     = out_valid ? w_data[r_rd_idx] : '0;
    // live slot during EMIT; latched copy afterwards while the buffer refills
    assign median       = r_med_vld ? w_data[MED_IDX] : r_median;
    assign median_valid = r_med_vld;
    assign w_unused     = ^{w_le[N-1], w_vld[N-1]};
    for (genvar i = 0; i < N; i++) begin : g_cell
        if (i == 0) begin : g_first
            sort_insert_cell #(.W(W)) u_cell (
                .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_acc(w_acc), .i_din(in_data),
                .i_low_le(1'b1), .i_low_data('0), .i_low_vld(1'b0),
                .o_le(w_le[i]), .o_data(w_data[i]), .o_vld(w_vld[i])
            );
        end else begin : g_rest
            sort_insert_cell #(.W(W)) u_cell (
                .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_acc(w_acc), .i_din(in_data),
                .i_low_le(w_le[i-1]), .i_low_data(w_data[i-1]), .i_low_vld(w_vld[i-1]),
                .o_le(w_le[i]), .o_data(w_data[i]), .o_vld(w_vld[i])
            );
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LOAD;
            r_count   <= '0;
            r_rd_idx  <= '0;
            r_median  <= '0;
            r_med_vld <= 1'b0;
        end else begin
            if (w_acc) r_count <= r_count + CW'(1);
            if (w_done) begin
                r_state   <= EMIT;
                r_med_vld <= 1'b1;
            end
            if (w_take) r_rd_idx <= r_rd_idx + CW'(1);
            if (w_clr) begin
                r_state   <= LOAD;
                r_count   <= '0;
                r_rd_idx  <= '0;
                r_med_vld <= 1'b0;
                r_median  <= w_data[MED_IDX];
            end
        end
    end
endmodule
